// File: rtl/lfsr_param_gen.sv
// Parametrised Fibonacci LFSR with runtime seed load, zero-state lockup recovery
// and a hardware period-measurement engine.
module lfsr_param_gen #(
    parameter int          WIDTH = 8,
    parameter logic [31:0] TAPS  = 32'hB8,
    parameter logic [31:0] SEED  = 32'd1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENA,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] SEED_IN,
    input  logic             MEAS_START,
    output logic [WIDTH-1:0] LFSR_out,
    output logic             LOCKUP,
    output logic             MEAS_BUSY,
    output logic             MEAS_DONE,
    output logic             MEAS_ABORT,
    output logic [WIDTH-1:0] PERIOD
);

    localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_VAL = SEED[WIDTH-1:0];

    typedef enum logic {
        IDLE,
        COUNT
    } meas_state_e;

    meas_state_e      meas_q, meas_d;
    logic [WIDTH-1:0] lfsr_d, step;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, cnt_n;
    logic [WIDTH-1:0] period_d;
    logic             lockup_d, done_d, abort_d;
    logic             zero_state;

    assign zero_state = (LFSR_out == '0);
    assign step       = {LFSR_out[WIDTH-2:0], ^(LFSR_out & TAP_MASK)};
    assign cnt_n      = cnt_q + 1'b1;
    assign MEAS_BUSY  = (meas_q == COUNT);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        lfsr_d   = LFSR_out;
        lockup_d = 1'b0;
        if (LOAD) begin
            if (SEED_IN != '0) begin
                lfsr_d = SEED_IN;
            end else begin
                lfsr_d   = SEED_VAL;
                lockup_d = 1'b1;
            end
        end else if (zero_state) begin
            lfsr_d   = SEED_VAL;
            lockup_d = 1'b1;
        end else if (ENA) begin
            lfsr_d = step;
        end
    end

    // Reference is the state the LFSR holds after the start edge; the period is the
    // number of enabled steps until that state reappears.
    always_comb begin
        meas_d   = meas_q;
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        period_d = PERIOD;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        case (meas_q)
            IDLE: begin
                if (MEAS_START && !LOAD) begin
                    ref_d  = lfsr_d;
                    cnt_d  = '0;
                    meas_d = COUNT;
                end
            end
            COUNT: begin
                if (LOAD || zero_state) begin
                    abort_d = 1'b1;
                    meas_d  = IDLE;
                end else if (ENA) begin
                    if (step == ref_q) begin
                        period_d = cnt_n;
                        done_d   = 1'b1;
                        meas_d   = IDLE;
                    end else begin
                        cnt_d = cnt_n;
                    end
                end
            end
            default: meas_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            LFSR_out   <= SEED_VAL;
            LOCKUP     <= 1'b0;
            meas_q     <= IDLE;
            ref_q      <= '0;
            cnt_q      <= '0;
            PERIOD     <= '0;
            MEAS_DONE  <= 1'b0;
            MEAS_ABORT <= 1'b0;
        end else begin
            LFSR_out   <= lfsr_d;
            LOCKUP     <= lockup_d;
            meas_q     <= meas_d;
            ref_q      <= ref_d;
            cnt_q      <= cnt_d;
            PERIOD     <= period_d;
            MEAS_DONE  <= done_d;
            MEAS_ABORT <= abort_d;
        end
    end

endmodule

// File: tb/tb_lfsr_param_gen.sv
// Directed bench for lfsr_param_gen: default 8-bit instance plus two 4-bit
// instances (maximal x^4+x+1 and non-maximal mask 4'hF).
module tb_lfsr_param_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena, load, start;
    logic [7:0] seed;
    logic [3:0] seed4;
    logic       load4;

    logic [7:0] lfsr, period;
    logic       lockup, busy, done, abort;
    logic [3:0] lfsr_c, period_c, lfsr_f, period_f;
    logic       lockup_c, busy_c, done_c, abort_c;
    logic       lockup_f, busy_f, done_f, abort_f;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lfsr_param_gen u_dut (
        .CLK(clk), .RST(rst), .ENA(ena), .LOAD(load), .SEED_IN(seed), .MEAS_START(start),
        .LFSR_out(lfsr), .LOCKUP(lockup), .MEAS_BUSY(busy), .MEAS_DONE(done),
        .MEAS_ABORT(abort), .PERIOD(period)
    );

    lfsr_param_gen #(.WIDTH(4), .TAPS(32'hC)) u_c (
        .CLK(clk), .RST(rst), .ENA(ena), .LOAD(load4), .SEED_IN(seed4), .MEAS_START(start),
        .LFSR_out(lfsr_c), .LOCKUP(lockup_c), .MEAS_BUSY(busy_c), .MEAS_DONE(done_c),
        .MEAS_ABORT(abort_c), .PERIOD(period_c)
    );

    lfsr_param_gen #(.WIDTH(4), .TAPS(32'hF)) u_f (
        .CLK(clk), .RST(rst), .ENA(ena), .LOAD(load4), .SEED_IN(seed4), .MEAS_START(start),
        .LFSR_out(lfsr_f), .LOCKUP(lockup_f), .MEAS_BUSY(busy_f), .MEAS_DONE(done_f),
        .MEAS_ABORT(abort_f), .PERIOD(period_f)
    );

    typedef struct {
        logic       ena;
        logic       load;
        logic [7:0] seed;
        logic [7:0] exp_lfsr;
        logic       exp_lockup;
        logic [3:0] exp_f;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a measurement, then step until DONE; returns edges after the start edge.
    task automatic measure(input bit stall_mode, output int edges, output int stalls);
        edges  = 0;
        stalls = 0;
        ena    = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        while (edges < 2000) begin
            ena = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!ena) stalls++;
            tick();
            edges++;
            if (done) break;
        end
    endtask

    initial begin
        int edges, stalls;

        vecs[0]  = '{1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 4'h3};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 8'h04, 1'b0, 4'h6};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 8'h08, 1'b0, 4'hC};
        vecs[3]  = '{1'b1, 1'b0, 8'h00, 8'h11, 1'b0, 4'h8};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 8'h23, 1'b0, 4'h1};
        vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'h01, 1'b1, 4'h1};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 4'h1};
        vecs[7]  = '{1'b0, 1'b1, 8'h5A, 8'h5A, 1'b0, 4'h1};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 8'hB4, 1'b0, 4'h3};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'hB4, 1'b0, 4'h3};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 8'h69, 1'b0, 4'h6};

        rst   = 1'b1;
        ena   = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        seed  = 8'h00;
        seed4 = 4'h0;
        load4 = 1'b0;
        #12;
        check("reset_lfsr", lfsr, 8'h01);
        check("reset_period", period, 8'h00);
        check("reset_flags", {lockup, busy, done, abort}, 4'b0000);
        check("reset_lfsr_f", lfsr_f, 4'h1);
        tick();
        rst = 1'b0;

        foreach (vecs[i]) begin
            ena  = vecs[i].ena;
            load = vecs[i].load;
            seed = vecs[i].seed;
            tick();
            check($sformatf("vec%0d_lfsr", i), lfsr, vecs[i].exp_lfsr);
            check($sformatf("vec%0d_lockup", i), lockup, vecs[i].exp_lockup);
            check($sformatf("vec%0d_lfsr_f", i), lfsr_f, vecs[i].exp_f);
        end
        load = 1'b0;
        seed = 8'h00;

        // Continuous enable: DONE exactly 255 edges after the start edge.
        measure(1'b0, edges, stalls);
        check("meas_edges", edges, 255);
        check("meas_period", period, 8'd255);
        check("meas_busy_drop", busy, 0);
        check("period_c", period_c, 4'd15);
        check("period_f", period_f, 4'd5);
        ena = 1'b0;
        tick();
        check("done_one_pulse", done, 0);

        // Random stalls delay DONE by exactly the stall count.
        measure(1'b1, edges, stalls);
        check("stall_edges", edges, 255 + stalls);
        check("stall_period", period, 8'd255);
        ena = 1'b0;
        tick();

        // START coincident with LOAD is ignored.
        load  = 1'b1;
        seed  = 8'h33;
        start = 1'b1;
        tick();
        load  = 1'b0;
        start = 1'b0;
        check("start_with_load_busy", busy, 0);
        check("start_with_load_lfsr", lfsr, 8'h33);

        // LOAD during COUNT aborts and keeps PERIOD.
        ena   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("abort_pre_busy", busy, 1);
        load = 1'b1;
        seed = 8'h5A;
        tick();
        load = 1'b0;
        ena  = 1'b0;
        check("abort_pulse", abort, 1);
        check("abort_busy", busy, 0);
        check("abort_period", period, 8'd255);
        check("abort_lfsr", lfsr, 8'h5A);
        check("abort_no_done", done, 0);
        tick();
        check("abort_one_pulse", abort, 0);

        // Reset mid-measurement: IDLE immediately, no flags afterwards.
        ena   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("rst_mid_flags", {lockup, busy, done, abort}, 4'b0000);
        check("rst_mid_lfsr", lfsr, 8'h01);
        check("rst_mid_period", period, 8'h00);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("post_rst_flags%0d", k), {lockup, busy, done, abort}, 4'b0000);
        end
        check("post_rst_lfsr", lfsr, 8'h23);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
